// File: rtl/decoder3x8_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides.
// A scan request walks all eight one-hot codes, each separated by SCAN_GAP idle cycles.
module decoder3x8_seq #(
   parameter int unsigned SCAN_GAP = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_code,
   input  logic       in_en,
   input  logic       scan_start,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_onehot,
   output logic [2:0] out_code,
   output logic       scan_busy,
   output logic       scan_done
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [3:0] GAP_LOAD = 4'(SCAN_GAP);

   state_t     state_q, state_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_onehot_q, out_onehot_d;
   logic [2:0] out_code_q, out_code_d;
   logic       out_scan_q, out_scan_d;
   logic [2:0] beat_idx_q, beat_idx_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;
   logic       scan_done_q, scan_done_d;
   logic       in_ready_c;
   logic       out_fire;
   logic [2:0] next_idx;

   function automatic logic [7:0] decode(input logic [2:0] code);
      return 8'h01 << code;
   endfunction

   assign out_fire = out_valid_q & out_ready;
   assign next_idx = 3'(beat_idx_q + 3'd1);

   // out_scan_q marks whether the held beat belongs to the scan, so a beat left
   // over from pass-through mode drains without advancing the scan index.
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_onehot_d = out_onehot_q;
      out_code_d   = out_code_q;
      out_scan_d   = out_scan_q;
      beat_idx_d   = beat_idx_q;
      gap_cnt_d    = gap_cnt_q;
      scan_done_d  = 1'b0;
      in_ready_c   = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready_c = (!out_valid_q | out_ready) & !scan_start;
            if (scan_start) begin
               state_d    = SCAN;
               beat_idx_d = 3'd0;
               gap_cnt_d  = 4'd0;
               if (out_fire) begin
                  out_valid_d = 1'b0;
               end
            end else if (in_valid && in_ready_c) begin
               out_valid_d  = 1'b1;
               out_code_d   = in_code;
               out_onehot_d = in_en ? decode(in_code) : 8'h00;
               out_scan_d   = 1'b0;
            end else if (out_fire) begin
               out_valid_d = 1'b0;
            end
         end

         SCAN: begin
            if (out_valid_q) begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  if (out_scan_q) begin
                     if (beat_idx_q == 3'd7) begin
                        state_d     = IDLE;
                        beat_idx_d  = 3'd0;
                        gap_cnt_d   = 4'd0;
                        out_scan_d  = 1'b0;
                        scan_done_d = 1'b1;
                     end else begin
                        beat_idx_d = next_idx;
                        if (SCAN_GAP == 0) begin
                           out_valid_d  = 1'b1;
                           out_code_d   = next_idx;
                           out_onehot_d = decode(next_idx);
                           out_scan_d   = 1'b1;
                        end else begin
                           gap_cnt_d = GAP_LOAD;
                        end
                     end
                  end
               end
            end else if (gap_cnt_q > 4'd1) begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end else begin
               // A count of one means this is the last idle cycle, so load now.
               gap_cnt_d    = 4'd0;
               out_valid_d  = 1'b1;
               out_code_d   = beat_idx_q;
               out_onehot_d = decode(beat_idx_q);
               out_scan_d   = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         out_valid_q  <= 1'b0;
         out_onehot_q <= 8'h00;
         out_code_q   <= 3'd0;
         out_scan_q   <= 1'b0;
         beat_idx_q   <= 3'd0;
         gap_cnt_q    <= 4'd0;
         scan_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_onehot_q <= out_onehot_d;
         out_code_q   <= out_code_d;
         out_scan_q   <= out_scan_d;
         beat_idx_q   <= beat_idx_d;
         gap_cnt_q    <= gap_cnt_d;
         scan_done_q  <= scan_done_d;
      end
   end

   assign in_ready   = rst_n & in_ready_c;
   assign out_valid  = out_valid_q;
   assign out_onehot = out_onehot_q;
   assign out_code   = out_code_q;
   assign scan_busy  = (state_q == SCAN);
   assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_decoder3x8_seq.sv
// Self-checking bench for decoder3x8_seq: directed cases with literal expectations
// plus a randomized stream checked every cycle against a transaction-level model.
module tb_decoder3x8_seq;

   localparam int unsigned SCAN_GAP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_code = 3'd0;
   logic       in_en = 1'b0;
   logic       scan_start = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_onehot;
   logic [2:0] out_code;
   logic       scan_busy;
   logic       scan_done;

   int checks = 0;
   int failures = 0;

   decoder3x8_seq #(.SCAN_GAP(SCAN_GAP)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_code(in_code),
      .in_en(in_en),
      .scan_start(scan_start),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_onehot(out_onehot),
      .out_code(out_code),
      .scan_busy(scan_busy),
      .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] code, input logic en,
                                input logic ss, input logic ordy);
      in_valid   = v;
      in_code    = code;
      in_en      = en;
      scan_start = ss;
      out_ready  = ordy;
   endtask

   // Transaction-level model: queue of beats the output must deliver in order,
   // entry = {is_scan, code[2:0], onehot[7:0]}.
   logic [11:0] exp_q[$];
   logic [11:0] head;
   bit          m_scan = 0;
   bit          m_ov = 0;
   bit          done_exp = 0;
   bit          gap_track = 0;
   bit          was_scan;
   int          gap_run = 0;
   int          scan_left = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_scan    = 0;
         m_ov      = 0;
         done_exp  = 0;
         gap_track = 0;
         gap_run   = 0;
         scan_left = 0;
      end else begin
         checkOutput("in_ready", in_ready, !m_scan && (!out_valid || out_ready) && !scan_start);
         checkOutput("scan_busy", scan_busy, m_scan);
         checkOutput("scan_done", scan_done, done_exp);
         if (!m_scan) checkOutput("out_valid", out_valid, m_ov);
         if (out_valid) begin
            if (exp_q.size() == 0) checkOutput("unexpected_beat", 1, 0);
            else checkOutput("out_beat", {out_code, out_onehot}, {21'd0, exp_q[0][10:0]});
         end
         if (gap_track) begin
            if (out_valid) begin
               checkOutput("scan_gap", gap_run, SCAN_GAP);
               gap_track = 0;
            end else begin
               gap_run++;
            end
         end

         // Predict what the coming rising edge does.
         was_scan = m_scan;
         done_exp = 0;
         if (out_valid && out_ready && exp_q.size() > 0) begin
            head = exp_q.pop_front();
            m_ov = 0;
            if (head[11]) begin
               scan_left--;
               if (scan_left == 0) begin
                  m_scan   = 0;
                  done_exp = 1;
               end else begin
                  gap_track = 1;
                  gap_run   = 0;
               end
            end
         end
         if (!was_scan && scan_start) begin
            m_scan    = 1;
            scan_left = 8;
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 3'(i), 8'h01 << i});
         end else if (!was_scan && in_valid && in_ready) begin
            exp_q.push_back({1'b0, in_code, in_en ? (8'h01 << in_code) : 8'h00});
            m_ov = 1;
         end
      end
   end

   initial begin
      int busy_cnt, done_cnt, beat_cnt, acc, cyc;
      logic [7:0] first_oh;
      bit seen_first, found;

      // Reset behaviour
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_onehot", out_onehot, 8'h00);
      checkOutput("rst_out_code", out_code, 0);
      checkOutput("rst_scan_busy", scan_busy, 0);
      checkOutput("rst_scan_done", scan_done, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // Pass-through decode
      @(posedge clk); #1;
      applyStimulus(1, 3'd5, 1, 0, 1);
      @(posedge clk); #1;
      checkOutput("pt_onehot_5", out_onehot, 8'h20);
      checkOutput("pt_code_5", out_code, 5);
      applyStimulus(1, 3'd2, 0, 0, 1);
      @(posedge clk); #1;
      checkOutput("pt_onehot_dis", out_onehot, 8'h00);
      checkOutput("pt_code_dis", out_code, 2);

      // Backpressure hold
      applyStimulus(1, 3'd3, 1, 0, 1);
      @(posedge clk); #1;
      checkOutput("bp_onehot_3", out_onehot, 8'h08);
      applyStimulus(1, 3'd6, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_hold_onehot", out_onehot, 8'h08);
         checkOutput("bp_hold_code", out_code, 3);
         checkOutput("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1 checkOutput("bp_release_ready", in_ready, 1);
      @(posedge clk); #1;
      checkOutput("bp_next_onehot", out_onehot, 8'h40);
      checkOutput("bp_next_code", out_code, 6);

      // Scan with a colliding input beat
      applyStimulus(1, 3'd1, 1, 1, 1);
      #1 checkOutput("collide_in_ready", in_ready, 0);
      @(posedge clk); #1;
      applyStimulus(0, 3'd0, 0, 0, 1);
      busy_cnt = 0; done_cnt = 0; beat_cnt = 0; seen_first = 0; first_oh = 8'h00;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (scan_busy) busy_cnt++;
         if (scan_done) done_cnt++;
         if (out_valid && out_ready && scan_busy) beat_cnt++;
         if (out_valid && !seen_first) begin
            seen_first = 1;
            first_oh   = out_onehot;
         end
      end
      checkOutput("scan_first_beat", first_oh, 8'h01);
      checkOutput("scan_done_pulses", done_cnt, 1);
      checkOutput("scan_beat_count", beat_cnt, 8);
      checkOutput("scan_busy_span", (busy_cnt >= 23 && busy_cnt <= 25), 1);

      // Reset in the middle of a scan
      @(posedge clk); #1;
      applyStimulus(0, 3'd0, 0, 1, 1);
      @(posedge clk); #1;
      scan_start = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (out_valid && out_code == 3'd4) found = 1;
      end
      checkOutput("midscan_beat4_seen", found, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_out_onehot", out_onehot, 8'h00);
      checkOutput("midrst_out_code", out_code, 0);
      checkOutput("midrst_scan_busy", scan_busy, 0);
      checkOutput("midrst_scan_done", scan_done, 0);
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_rst_in_ready", in_ready, 1);
      checkOutput("post_rst_scan_done", scan_done, 0);

      // Random stream of 1000 accepted beats
      acc = 0;
      cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
         applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("random_accepted", acc, 1000);

      // Drain everything still owed
      applyStimulus(0, 3'd0, 0, 0, 1);
      for (int i = 0; i < 300 && (exp_q.size() != 0 || m_scan); i++) begin
         @(posedge clk); #2;
      end
      checkOutput("drain_queue_empty", exp_q.size(), 0);
      checkOutput("drain_scan_idle", scan_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decoder3x8_seq.md
DECODER3X8_SEQ -- requirements
Module: decoder3x8_seq

Interface
REQ-001 The block SHALL have parameter SCAN_GAP, default 2, giving the idle cycles inserted between scan beats (legal range 0..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, asserted when in_code and in_en are presented.
REQ-005 The block SHALL have port in_ready, output, 1, the acceptance flag; a beat transfers when in_valid and in_ready are both 1 at a clock edge.
REQ-006 The block SHALL have port in_code, input, 3, the binary index to decode.
REQ-007 The block SHALL have port in_en, input, 1, the decode enable sampled with in_code; 0 yields an all-zero word.
REQ-008 The block SHALL have port scan_start, input, 1, a single-cycle request to walk all eight one-hot codes.
REQ-009 The block SHALL have port out_valid, output, 1, asserted while out_onehot and out_code hold a beat.
REQ-010 The block SHALL have port out_ready, input, 1, the downstream acceptance flag.
REQ-011 The block SHALL have port out_onehot, output, 8, the decoded word.
REQ-012 The block SHALL have port out_code, output, 3, the index that produced out_onehot.
REQ-013 The block SHALL have port scan_busy, output, 1, high while in SCAN.
REQ-014 The block SHALL have port scan_done, output, 1, a one-cycle pulse when a scan completes.

Function
REQ-015 The FSM SHALL have states IDLE and SCAN only; the output register provides the pass-through holding stage.
REQ-016 In IDLE, in_ready SHALL equal (!out_valid | out_ready) & !scan_start.
REQ-017 An accepted beat SHALL appear on the next edge: out_valid=1, out_code=in_code, out_onehot=(1<<in_code) if in_en=1, else 8'h00.
REQ-018 Decode latency SHALL be exactly 1 cycle; back-to-back beats SHALL sustain one per cycle while out_ready=1.
REQ-019 While out_valid=1 and out_ready=0, out_onehot and out_code SHALL hold stable, and no new beat SHALL be accepted.
REQ-020 When out_valid & out_ready occur with no new beat loaded, out_valid SHALL clear on the next edge.
REQ-021 In IDLE, scan_start=1 SHALL take priority over in_valid in the same cycle; the FSM SHALL enter SCAN with beat index 0.
REQ-022 A pending out_valid beat SHALL complete its handshake before the first scan beat is loaded.
REQ-023 In SCAN, in_ready SHALL be 0 and scan_busy SHALL be 1.
REQ-024 Scan beats SHALL be 8'h01, 8'h02, ..., 8'h80, with out_code 0..7, all treated as in_en=1.
REQ-025 Each scan beat SHALL be held until handshaken; after each handshake, a gap counter SHALL wait SCAN_GAP cycles with out_valid=0 before loading the next beat (no gap when SCAN_GAP=0).
REQ-026 The 3-bit beat index SHALL wrap 7->0 on the handshake of beat 7; that edge SHALL clear out_valid, pulse scan_done for one cycle, and return the FSM to IDLE.
REQ-027 scan_start during SCAN SHALL be ignored; scan_start in the cycle after scan_done SHALL start a new scan.
REQ-028 in_code values are always in range (3 bits), so no illegal-input handling SHALL exist; in_code and in_en SHALL be ignored when in_valid=0.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force: FSM=IDLE, out_valid=0, out_onehot=8'h00, out_code=3'b000, scan_busy=0, scan_done=0, beat index=0, gap counter=0.
REQ-030 in_ready SHALL be 0 while rst_n=0 and SHALL follow REQ-016 from the first edge after deassertion.
REQ-031 Reset mid-scan or mid-handshake SHALL abandon the scan or beat without a scan_done pulse.

Verification
REQ-032 Pass-through: in_code=5 with in_en=1, out_ready=1 -> next cycle out_onehot=8'h20, out_code=5; in_code=2 with in_en=0 -> out_onehot=8'h00, out_code=2.
REQ-033 Backpressure: out_ready=0 for 4 cycles after beat code 3 -> out_onehot holds 8'h08, in_ready=0; out_ready=1 -> next beat accepted the same cycle.
REQ-034 Scan with SCAN_GAP=2, out_ready=1 -> 8 beats 8'h01..8'h80, each followed by 2 cycles of out_valid=0; scan_done pulses once; scan_busy spans 8+8*2 cycles, +/-1.
REQ-035 Collision: scan_start and in_valid in the same cycle in IDLE -> in_ready=0, input beat not consumed, first scan beat is 8'h01.
REQ-036 Reset mid-scan: rst_n=0 during beat 4 -> all outputs zero asynchronously, no scan_done; after release, in_ready=1.
REQ-037 Random stream of 1000 beats with random out_ready -> every accepted beat observed exactly once, in order, with correct one-hot value.
